// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider, one quotient bit per iterate cycle.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        iter_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    shifted = {rem_q, quo_q[31]};
    // partial remainder stays below divisor, so the low 32 bits of the difference are exact
    diff    = shifted[31:0] - dsr_q;
    fits    = shifted[32] | (shifted[31:0] >= dsr_q);
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
    end else if (iter_i) begin
      quo_d = {quo_q[30:0], fits};
      rem_d = fits ? diff : shifted[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Define MULDIV_DIV_EN to build the divider; otherwise div/rem ops return 0.
module execute_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [2:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  RdE,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] MulDivResultE,
  output logic [4:0]  MulDivRdE
);

  localparam logic [4:0] LAST_CNT = 5'(MULDIV_ITER - 1);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op, op_q, op_d;
  logic [4:0]    cnt_q, cnt_d, rd_q, rd_d;
  logic [31:0]   mcand_q, mcand_d, res_q, res_d;
  logic [63:0]   prod_q, prod_d, prod_step, prod_fin;
  logic          negp_q, negp_d, nega_q, nega_d, special_q, special_d;
  logic          busy;

  logic          a_signed, b_signed, sa, sb, is_div, is_rem, div_zero, div_ovf, take_special;
  logic [31:0]   a_mag, b_mag, special_val, mul_res, div_res, fin_res;
  logic [32:0]   sum;
  logic [31:0]   quot, rem;

  always_comb begin
    op       = muldiv_op_e'(MulDivOpE);
    a_signed = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sa       = a_signed & SrcAE[31];
    sb       = b_signed & SrcBE[31];
    a_mag    = neg_if(sa, SrcAE);
    b_mag    = neg_if(sb, SrcBE);
    is_div   = MulDivOpE[2];
    is_rem   = MulDivOpE[1];
    div_zero = (SrcBE == '0);
    div_ovf  = (op inside {OP_DIV, OP_REM}) && (SrcAE == 32'h8000_0000) && (SrcBE == '1);
`ifdef MULDIV_DIV_EN
    take_special = is_div & (div_zero | div_ovf);
    special_val  = div_zero ? (is_rem ? SrcAE : '1) : (is_rem ? '0 : 32'h8000_0000);
`else
    take_special = is_div;
    special_val  = '0;
`endif
  end

  // Right-shifting shift-add: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    sum       = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? mcand_q : 32'd0)};
    prod_step = {sum, prod_q[31:1]};
    prod_fin  = negp_q ? (~prod_q + 64'd1) : prod_q;
    mul_res   = (op_q == OP_MUL) ? prod_fin[31:0] : prod_fin[63:32];
    div_res   = op_q[1] ? neg_if(nega_q, rem) : neg_if(negp_q, quot);
    fin_res   = special_q ? res_q : (op_q[2] ? div_res : mul_res);
  end

`ifdef MULDIV_DIV_EN
  logic div_start, div_iter;

  muldiv_divider u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .iter_i     (div_iter),
    .quot_o     (quot),
    .rem_o      (rem)
  );
`else
  assign quot = '0;
  assign rem  = '0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    res_d     = res_q;
    negp_d    = negp_q;
    nega_d    = nega_q;
    special_d = special_q;
    busy      = 1'b0;
    DoneE     = 1'b0;
`ifdef MULDIV_DIV_EN
    div_start = 1'b0;
    div_iter  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (StartE && !FlushE) begin
          busy      = 1'b1;
          op_d      = op;
          rd_d      = RdE;
          negp_d    = sa ^ sb;
          nega_d    = sa;
          cnt_d     = '0;
          special_d = take_special;
          if (take_special) begin
            res_d   = special_val;
            state_d = ST_DONE;
          end else if (is_div) begin
`ifdef MULDIV_DIV_EN
            div_start = 1'b1;
`endif
            state_d   = ST_DIV;
          end else begin
            mcand_d = a_mag;
            prod_d  = {32'd0, b_mag};
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        busy = 1'b1;
        if (FlushE) begin
          state_d = ST_IDLE;
        end else begin
          if (state_q == ST_MUL) begin
            prod_d = prod_step;
          end
`ifdef MULDIV_DIV_EN
          else begin
            div_iter = 1'b1;
          end
`endif
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!FlushE) begin
          DoneE = 1'b1;
          res_d = fin_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      rd_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      res_q     <= '0;
      negp_q    <= 1'b0;
      nega_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      res_q     <= res_d;
      negp_q    <= negp_d;
      nega_q    <= nega_d;
      special_q <= special_d;
    end
  end

  // The accept term is combinational on StartE, so it must be masked while reset is held.
  assign BusyE         = busy & rst_n;
  assign MulDivResultE = (state_q == ST_DONE) ? fin_res : res_q;
  assign MulDivRdE     = rd_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: directed vectors, decoupled monitor.
module tb_execute_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        BusyE, DoneE;
  logic [31:0] MulDivResultE;
  logic [4:0]  MulDivRdE;

  execute_muldiv_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .StartE        (StartE),
    .MulDivOpE     (MulDivOpE),
    .SrcAE         (SrcAE),
    .SrcBE         (SrcBE),
    .RdE           (RdE),
    .FlushE        (FlushE),
    .BusyE         (BusyE),
    .DoneE         (DoneE),
    .MulDivResultE (MulDivResultE),
    .MulDivRdE     (MulDivRdE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edges  = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every DoneE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (DoneE === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=result 0x%08h expected=no DoneE", MulDivResultE);
      end else begin
        mon_e = sb.pop_front();
        check("result", MulDivResultE, mon_e.res);
        check("rd", {27'd0, MulDivRdE}, {27'd0, mon_e.rd});
        check("latency", edges - mon_e.acc, mon_e.lat);
        check("busy_in_done", {31'd0, BusyE}, 32'd0);
      end
    end
  end

  // Called at a negedge; holds StartE through DONE like a stalled pipeline would.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int unsigned lat);
    exp_t        e;
    int unsigned busy;
    bit          done;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    RdE       = rd;
    StartE    = 1'b1;
    e.res = res;
    e.rd  = rd;
    e.lat = lat;
    e.acc = edges;
    sb.push_back(e);
    #1;
    check("busy_cycle0", {31'd0, BusyE}, 32'd1);
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (BusyE) busy++;
      if (DoneE) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no DoneE expected=DoneE op=%0d", op);
    end
    check("busy_cycles", busy, lat - 1);
    @(posedge clk);
    #1 StartE = 1'b0;
    @(negedge clk);
    check("result_hold", MulDivResultE, res);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    StartE    = 1'b0;
    FlushE    = 1'b0;
    MulDivOpE = '0;
    SrcAE     = '0;
    SrcBE     = '0;
    RdE       = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, BusyE}, 32'd0);
    check("rst_done", {31'd0, DoneE}, 32'd0);
    check("rst_result", MulDivResultE, 32'd0);
    check("rst_rd", {27'd0, MulDivRdE}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
    run_op(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780, 33);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 33);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, DIV_EN ? 32'hFFFF_FFFD : 32'd0, DIV_EN ? 33 : 1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 33 : 1);
    run_op(3'd5, 32'h8000_0000, 32'd0, 5'd13, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1);
    run_op(3'd7, 32'h8000_0000, 32'd0, 5'd14, DIV_EN ? 32'h8000_0000 : 32'd0, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, DIV_EN ? 32'h8000_0000 : 32'd0, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
    run_op(3'd5, 32'd100, 32'd7, 5'd17, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1);
    run_op(3'd7, 32'd100, 32'd7, 5'd18, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 33 : 1);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd19, DIV_EN ? 32'd1 : 32'd0, DIV_EN ? 33 : 1);

    // Flush a MUL in cycle 10; nothing is pushed for it.
    MulDivOpE = 3'd0;
    SrcAE     = 32'd3;
    SrcBE     = 32'd4;
    RdE       = 5'd20;
    StartE    = 1'b1;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    @(posedge clk);
    #1;
    StartE = 1'b0;
    FlushE = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, BusyE}, 32'd0);
    check("flush_done", {31'd0, DoneE}, 32'd0);
    run_op(3'd0, 32'd9, 32'd11, 5'd21, 32'd99, 33);

    // Reset in cycle 5 of a long op, with StartE still held.
    MulDivOpE = DIV_EN ? 3'd4 : 3'd0;
    SrcAE     = 32'd1000;
    SrcBE     = 32'd3;
    RdE       = 5'd22;
    StartE    = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, BusyE}, 32'd0);
    check("midrst_done", {31'd0, DoneE}, 32'd0);
    check("midrst_result", MulDivResultE, 32'd0);
    check("midrst_rd", {27'd0, MulDivRdE}, 32'd0);
    StartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op(3'd4, 32'd1000, 32'd3, 5'd23, DIV_EN ? 32'd333 : 32'd0, DIV_EN ? 33 : 1);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd24, 32'hFFFF_FFFE, 33);

    repeat (40) @(negedge clk);
    check("queue_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
EXECUTE_MULDIV_UNIT -- requirements
Module: execute_muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock shared with all pipeline registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 StartE  input  1  high while a mul/div instruction occupies Execute.
REQ-005 MulDivOpE  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SrcAE, SrcBE  input  32 each  forwarded operands (rs1, rs2).
REQ-007 RdE  input  5  destination register of the Execute instruction.
REQ-008 FlushE  input  1  kill the Execute instruction.
REQ-009 BusyE  output  1  stall request to the hazard unit; holds F, D, and the decode-to-execute register.
REQ-010 DoneE  output  1  one-cycle pulse; MulDivResultE is valid in this cycle.
REQ-011 MulDivResultE  output  32  result; MulDivRdE  output  5  latched RdE.

Function
REQ-012 FSM states: IDLE, MUL, DIV, DONE.
REQ-013 IDLE with StartE=1 and FlushE=0: latch op, operands and RdE; go to MUL (ops 0-3) or DIV (ops 4-7).
REQ-014 BusyE = (IDLE & StartE & ~FlushE) | MUL | DIV, combinational; BusyE=0 in DONE.
REQ-015 MUL/DIV: radix-2 iteration, one bit per cycle, 5-bit counter 0..31; the transition to DONE follows count 31.
REQ-016 Latency: start accepted at edge 0; DoneE is high in cycle 33; the pipeline advances on the following edge.
REQ-017 Signed ops: iterate on magnitudes; apply sign at DONE (product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA).
REQ-018 MUL returns the low 32 bits of the 64-bit product; MULH/MULHSU/MULHU return the high 32 bits, with operands interpreted as s*s, s*u, u*u.
REQ-019 Divide by zero: quotient 0xFFFFFFFF, remainder = SrcA; IDLE goes directly to DONE (DoneE in cycle 1).
REQ-020 Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0; goes directly to DONE.
REQ-021 DONE always returns to IDLE; StartE seen in DONE belongs to the same instruction and SHALL be ignored.
REQ-022 FlushE in MUL, DIV or DONE: go to IDLE on the next edge; DoneE SHALL NOT assert for the flushed op.
REQ-023 MulDivResultE and MulDivRdE hold their values outside DONE; consumers qualify them with DoneE.

Reset
REQ-024 rst_n low: state=IDLE, counter=0, BusyE=0, DoneE=0, MulDivResultE=0, MulDivRdE=0, all datapath registers=0.
REQ-025 Reset mid-operation SHALL abandon the operation with no DoneE; the first start after reset behaves normally.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined: all eight ops are supported as specified above.
REQ-027 Macro MULDIV_DIV_EN undefined: the divider is not built; ops 4-7 go IDLE->DONE with result 0 and DoneE in cycle 1.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encoding enum, the FSM state enum, and constant MULDIV_ITER=32.
REQ-029 The restoring divider SHALL be a sub-module, muldiv_divider (start, operands, iterate, quotient/remainder out), instantiated only under MULDIV_DIV_EN.
REQ-030 The multiplier shift-add datapath SHALL stay in the top module.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD -> BusyE high cycles 0-32; DoneE in cycle 33; result 0xFFFFFFEB; MulDivRdE = RdE.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 0x80000000 / 0 -> 0xFFFFFFFF, DoneE in cycle 1.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, DoneE in cycle 1; REM with the same operands -> 0.
REQ-035 FlushE in cycle 10 of a MUL -> IDLE at cycle 11; no DoneE; BusyE low; a new start at cycle 12 completes correctly.
REQ-036 rst_n low in cycle 5 of a DIV -> all outputs 0 immediately; no DoneE; with MULDIV_DIV_EN undefined, DIV -> result 0, DoneE in cycle 1.
